flash_burst_loader: RTL

// - Boot-time copier that sits directly upstream of the burst RAM (PSRAM) controller.
// - Waits for the controller to report init calibration.
// - Streams a contiguous image from SPI flash using READ 0x03.
// - Packs the received bytes into burst-RAM words.
// - Issues burst writes until TRANSFER_BURST_COUNT bursts are stored, then asserts done.
//

---
 rtl/flash_burst_loader_pkg.sv | 18 +
 rtl/flash_burst_loader_spi_byte_shifter.sv | 73 +++++++
 rtl/flash_burst_loader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/flash_burst_loader_pkg.sv
// Shared constants for the flash-to-burst-RAM boot loader: SPI command,
// bit counts and the loader state encoding.
package flash_burst_loader_pkg;

    localparam logic [7:0] FLASH_CMD_READ    = 8'h03;
    localparam int         SPI_BITS_PER_BYTE = 8;
    localparam int         SPI_CMD_BITS      = 32;

    typedef logic [2:0] state_t;

    localparam state_t WAIT_CALIB = 3'd0;
    localparam state_t CMD        = 3'd1;
    localparam state_t RECV       = 3'd2;
    localparam state_t WAIT_RAM   = 3'd3;
    localparam state_t WRITE      = 3'd4;
    localparam state_t DONE       = 3'd5;

endpackage

// File: rtl/flash_burst_loader_spi_byte_shifter.sv
// SPI mode-0 byte shifter running at clk/2. While i_run is high it streams
// bytes back to back: the next transmit byte is taken from i_tx_byte on the
// falling SCLK edge that ends a byte. i_stall holds SCLK low between bits so
// the flash clock pauses instead of restarting.
module flash_burst_loader_spi_byte_shifter
    import flash_burst_loader_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run,
    input  logic       i_stall,
    input  logic [7:0] i_tx_byte,
    input  logic       i_miso,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_byte_valid,
    output logic [7:0] o_rx_byte
);

    localparam logic [2:0] LAST_BIT = 3'(SPI_BITS_PER_BYTE - 1);

    logic       r_sclk;
    logic       r_mosi;
    logic       r_primed;
    logic       r_byte_valid;
    logic [2:0] r_bit_idx;
    logic [7:0] r_tx;
    logic [7:0] r_rx;

    // Bit engine: present MOSI while SCLK is low, sample MISO as SCLK rises.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_run) begin
            r_sclk       <= 1'b0;
            r_mosi       <= 1'b0;
            r_primed     <= 1'b0;
            r_byte_valid <= 1'b0;
            r_bit_idx    <= 3'd0;
            r_tx         <= 8'h00;
            r_rx         <= 8'h00;
        end else if (!r_primed) begin
            r_primed     <= 1'b1;
            r_sclk       <= 1'b0;
            r_mosi       <= i_tx_byte[7];
            r_tx         <= {i_tx_byte[6:0], 1'b0};
            r_bit_idx    <= 3'd0;
            r_byte_valid <= 1'b0;
        end else if (r_sclk) begin
            r_sclk       <= 1'b0;
            r_byte_valid <= 1'b0;
            if (r_bit_idx == LAST_BIT) begin
                r_mosi    <= i_tx_byte[7];
                r_tx      <= {i_tx_byte[6:0], 1'b0};
                r_bit_idx <= 3'd0;
            end else begin
                r_mosi    <= r_tx[7];
                r_tx      <= {r_tx[6:0], 1'b0};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end else if (!i_stall) begin
            r_sclk       <= 1'b1;
            r_rx         <= {r_rx[6:0], i_miso};
            r_byte_valid <= (r_bit_idx == LAST_BIT);
        end else begin
            r_byte_valid <= 1'b0;
        end
    end

    assign o_sclk       = r_sclk;
    assign o_mosi       = r_mosi;
    assign o_byte_valid = r_byte_valid;
    assign o_rx_byte    = r_rx;

endmodule

// File: rtl/flash_burst_loader.sv
// Boot-time copier: after the burst RAM reports calibration, reads a
// contiguous image from SPI flash (READ 0x03), packs bytes LSB-first into
// burst-RAM words, and writes them out as fixed-length bursts until the
// configured number of bursts is stored, then raises a sticky done.
module flash_burst_loader
    import flash_burst_loader_pkg::*;
#(
    parameter int          BURST_RAM_DEPTH_BITWIDTH = 4,
    parameter int          BURST_DATA_WIDTH         = 64,
    parameter int          BURST_LEN                = 4,
    parameter int          TRANSFER_BURST_COUNT     = 4,
    parameter logic [23:0] FLASH_READ_ADDR          = 24'h0,
    parameter int          START_RAM_ADDR           = 0
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_br_init_calib,
    input  logic                                i_br_busy,
    output logic                                o_br_cmd,
    output logic                                o_br_cmd_en,
    output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] o_br_addr,
    output logic [BURST_DATA_WIDTH-1:0]         o_br_wr_data,
    output logic [BURST_DATA_WIDTH/8-1:0]       o_br_data_mask,
    output logic                                o_flash_clk,
    input  logic                                i_flash_miso,
    output logic                                o_flash_mosi,
    output logic                                o_flash_cs,
    output logic                                o_done
);

    localparam int AW             = BURST_RAM_DEPTH_BITWIDTH;
    localparam int DW             = BURST_DATA_WIDTH;
    localparam int BYTES_PER_WORD = DW / 8;
    localparam int BYTE_IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int WORD_IDX_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int WR_IDX_W       = $clog2(BURST_LEN + 1);
    localparam int BURST_CNT_W    = (TRANSFER_BURST_COUNT > 1) ? $clog2(TRANSFER_BURST_COUNT) : 1;

    localparam logic [BYTE_IDX_W-1:0]  LAST_BYTE     = BYTE_IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [WORD_IDX_W-1:0]  LAST_WORD     = WORD_IDX_W'(BURST_LEN - 1);
    localparam logic [WR_IDX_W-1:0]    WR_END        = WR_IDX_W'(BURST_LEN);
    localparam logic [BURST_CNT_W-1:0] LAST_BURST    = BURST_CNT_W'(TRANSFER_BURST_COUNT - 1);
    localparam logic [1:0]             LAST_CMD_BYTE = 2'(SPI_CMD_BITS / SPI_BITS_PER_BYTE - 1);
    localparam logic [AW-1:0]          ADDR_START    = AW'(START_RAM_ADDR);
    localparam logic [AW-1:0]          ADDR_STEP     = AW'(BURST_LEN);

    state_t                  r_state;
    logic                    r_cs;
    logic [SPI_CMD_BITS-1:0] r_cmd_shift;
    logic [1:0]              r_cmd_byte_cnt;
    logic [BYTE_IDX_W-1:0]   r_byte_idx;
    logic [DW-1:0]           r_word_acc;
    logic [WORD_IDX_W-1:0]   r_word_cnt;
    logic [WR_IDX_W-1:0]     r_wr_idx;
    logic [BURST_CNT_W-1:0]  r_burst_cnt;
    logic [AW-1:0]           r_base;
    logic                    r_cmd_en;
    logic                    r_cmd;
    logic [AW-1:0]           r_addr;
    logic [DW-1:0]           r_wr_data;
    logic                    r_done;
    logic [DW-1:0]           r_buf [BURST_LEN];

    logic                    w_run;
    logic                    w_stall;
    logic [7:0]              w_tx_byte;
    logic                    w_byte_valid;
    logic [7:0]              w_rx_byte;
    logic [DW-1:0]           w_new_word;
    logic                    w_word_done;

    // The flash link runs from command start until the copy finishes; it is
    // paused whenever the burst buffer is full or being drained.
    assign w_run   = (r_state == CMD) || (r_state == RECV) ||
                     (r_state == WAIT_RAM) || (r_state == WRITE);
    assign w_stall = (r_state == WAIT_RAM) || (r_state == WRITE);

    // The shifter loads the next byte in the cycle a byte completes, before
    // the command register has shifted, so look one byte ahead then.
    assign w_tx_byte = w_byte_valid ? r_cmd_shift[SPI_CMD_BITS-9 -: 8]
                                    : r_cmd_shift[SPI_CMD_BITS-1 -: 8];

    flash_burst_loader_spi_byte_shifter u_spi_byte_shifter (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_run        (w_run),
        .i_stall      (w_stall),
        .i_tx_byte    (w_tx_byte),
        .i_miso       (i_flash_miso),
        .o_sclk       (o_flash_clk),
        .o_mosi       (o_flash_mosi),
        .o_byte_valid (w_byte_valid),
        .o_rx_byte    (w_rx_byte)
    );

    // Merge the freshly received byte into its lane of the word being built.
    always_comb begin
        w_new_word = r_word_acc;
        w_new_word[int'(r_byte_idx) * 8 +: 8] = w_rx_byte;
    end

    assign w_word_done = (r_state == RECV) && w_byte_valid && (r_byte_idx == LAST_BYTE);

    // Burst buffer: a completed word is parked until the burst is written out.
    always_ff @(posedge i_clk) begin
        if (w_word_done) begin
            r_buf[r_word_cnt] <= w_new_word;
        end
    end

    // Loader sequencing: calibration wait, flash command, packing, burst writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= WAIT_CALIB;
            r_cs           <= 1'b1;
            r_cmd_shift    <= '0;
            r_cmd_byte_cnt <= 2'd0;
            r_byte_idx     <= '0;
            r_word_acc     <= '0;
            r_word_cnt     <= '0;
            r_wr_idx       <= '0;
            r_burst_cnt    <= '0;
            r_base         <= ADDR_START;
            r_cmd_en       <= 1'b0;
            r_cmd          <= 1'b0;
            r_addr         <= '0;
            r_wr_data      <= '0;
            r_done         <= 1'b0;
        end else begin
            r_cmd_en <= 1'b0;
            r_cmd    <= 1'b0;
            case (r_state)
                WAIT_CALIB: begin
                    if (i_br_init_calib) begin
                        r_state        <= CMD;
                        r_cs           <= 1'b0;
                        r_cmd_shift    <= {FLASH_CMD_READ, FLASH_READ_ADDR};
                        r_cmd_byte_cnt <= 2'd0;
                    end
                end
                CMD: begin
                    if (w_byte_valid) begin
                        r_cmd_shift    <= {r_cmd_shift[SPI_CMD_BITS-9:0], 8'h00};
                        r_cmd_byte_cnt <= r_cmd_byte_cnt + 2'd1;
                        if (r_cmd_byte_cnt == LAST_CMD_BYTE) begin
                            r_state <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (w_byte_valid) begin
                        r_word_acc <= w_new_word;
                        if (r_byte_idx == LAST_BYTE) begin
                            r_byte_idx <= '0;
                            if (r_word_cnt == LAST_WORD) begin
                                r_word_cnt <= '0;
                                r_state    <= WAIT_RAM;
                            end else begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end
                end
                WAIT_RAM: begin
                    if (!i_br_busy) begin
                        r_state   <= WRITE;
                        r_cmd_en  <= 1'b1;
                        r_cmd     <= 1'b1;
                        r_addr    <= r_base;
                        r_wr_data <= r_buf[0];
                        r_wr_idx  <= WR_IDX_W'(1);
                    end
                end
                WRITE: begin
                    if (r_wr_idx == WR_END) begin
                        r_wr_idx    <= '0;
                        r_base      <= r_base + ADDR_STEP;
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                        if (r_burst_cnt == LAST_BURST) begin
                            r_state <= DONE;
                            r_cs    <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RECV;
                        end
                    end else begin
                        r_wr_data <= r_buf[r_wr_idx[WORD_IDX_W-1:0]];
                        r_wr_idx  <= r_wr_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_cs   <= 1'b1;
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= WAIT_CALIB;
                    r_cs    <= 1'b1;
                end
            endcase
        end
    end

    assign o_br_cmd       = r_cmd;
    assign o_br_cmd_en    = r_cmd_en;
    assign o_br_addr      = r_addr;
    assign o_br_wr_data   = r_wr_data;
    assign o_br_data_mask = '0;
    assign o_flash_cs     = r_cs;
    assign o_done         = r_done;

endmodule
